// File: rtl/stream_pkg.sv
// Shared constants for the stream reduce / result capture path.
//   DEFAULT_WIDTH : data width of reduced sums
//   DEFAULT_DEPTH : default result FIFO depth
//   DROP_CNT_W    : width of the saturating drop counter
//   TOTAL_CNT_W   : width of the wrapping accepted-sample counter
package stream_pkg;
   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 8;
   localparam int DROP_CNT_W    = 16;
   localparam int TOTAL_CNT_W   = 32;
endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
// Ports:
//   CLK   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module fifo_regfile #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/reduce_result_fifo.sv
// Captures each reduced sum on its vdata pulse into a show-ahead FIFO and
// drains it over a valid/ready handshake. Tracks occupancy, a sticky
// overflow flag, a saturating drop counter and a wrapping accepted counter.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   clear         : synchronous flush of FIFO and statistics
//   zdata, vdata  : upstream sum and its one-cycle valid pulse
//   out_data      : head entry (valid when out_valid)
//   out_valid     : FIFO not empty
//   out_ready     : consumer accepts head entry
//   level         : occupancy 0..DEPTH
//   overflow      : sticky, set on any dropped sample
//   drop_count    : dropped samples, saturating
//   total_count   : accepted samples, wrapping
module reduce_result_fifo
   import stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          clear,
   input  logic signed [WIDTH-1:0]       zdata,
   input  logic                          vdata,
   output logic signed [WIDTH-1:0]       out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic        [AW:0]            level,
   output logic                          overflow,
   output logic        [DROP_CNT_W-1:0]  drop_count,
   output logic        [TOTAL_CNT_W-1:0] total_count
);

   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;
   logic          flush;

   assign flush     = RST | clear;
   assign full      = (level == LEVEL_FULL);
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok   = vdata & (~full | pop);
   assign drop      = vdata & full & ~pop;

   fifo_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .CLK   (CLK),
      .we    (push_ok & ~flush),
      .waddr (wr_ptr),
      .wdata (zdata),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

   always_ff @(posedge CLK) begin
      if (flush) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         overflow    <= 1'b0;
         drop_count  <= '0;
         total_count <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push_ok) begin
            wr_ptr      <= wr_ptr + AW'(1);
            total_count <= total_count + TOTAL_CNT_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_CNT_W{1'b1}})
               drop_count <= drop_count + DROP_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_reduce_result_fifo.sv
module tb_reduce_result_fifo;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               clear = 1'b0;
   logic signed [31:0] zdata = '0;
   logic               vdata = 1'b0;
   logic signed [31:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [3:0]         level;
   logic               overflow;
   logic [15:0]        drop_count;
   logic [31:0]        total_count;

   int n_checks = 0;
   int n_pass   = 0;

   reduce_result_fifo #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .clear       (clear),
      .zdata       (zdata),
      .vdata       (vdata),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .level       (level),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .total_count (total_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
   endtask

   // Behavioural model: a queue of accepted samples plus counters.
   int  mq[$];
   bit  m_over;
   int  m_drop;
   int  m_total;
   bit  m_started = 0;

   always @(posedge CLK) begin
      bit m_pop;
      if (RST || clear) begin
         mq.delete();
         m_over  = 0;
         m_drop  = 0;
         m_total = 0;
      end else begin
         m_pop = (mq.size() != 0) && out_ready;
         if (m_pop) void'(mq.pop_front());
         if (vdata) begin
            if (mq.size() < 8) begin
               mq.push_back(int'(zdata));
               m_total++;
            end else begin
               m_over = 1;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
      m_started = 1;
   end

   always @(negedge CLK) begin
      if (m_started) begin
         check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("level", 32'(level), 32'(mq.size()));
         check("overflow", 32'(overflow), 32'(m_over));
         check("drop_count", 32'(drop_count), 32'(m_drop));
         check("total_count", total_count, 32'(m_total));
         if (mq.size() != 0) check("out_data", out_data, 32'(mq[0]));
      end
   end

   // Drive inputs for exactly one rising edge, then settle just after it.
   task automatic tick(input logic v, input int z, input logic r,
                       input logic c = 1'b0, input logic rs = 1'b0);
      vdata = v; zdata = z; out_ready = r; clear = c; RST = rs;
      @(posedge CLK);
      #2;
   endtask

   initial begin
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 1);
      check("lit_reset_valid", 32'(out_valid), 0);
      check("lit_reset_level", 32'(level), 0);

      // single sample
      tick(1, 1680, 0);
      check("lit_single_data", out_data, 1680);
      check("lit_single_level", 32'(level), 1);
      tick(0, 0, 1);
      check("lit_single_empty", 32'(out_valid), 0);
      check("lit_single_total", total_count, 1);

      // ordering
      tick(1, 120, 0); tick(1, 376, 0); tick(1, 632, 0); tick(1, 888, 0);
      check("lit_order_level", 32'(level), 4);
      check("lit_order_0", out_data, 120); tick(0, 0, 1);
      check("lit_order_1", out_data, 376); tick(0, 0, 1);
      check("lit_order_2", out_data, 632); tick(0, 0, 1);
      check("lit_order_3", out_data, 888); tick(0, 0, 1);
      check("lit_order_empty", 32'(out_valid), 0);

      // overflow
      for (int i = 1; i <= 10; i++) tick(1, i, 0);
      check("lit_ovf_level", 32'(level), 8);
      check("lit_ovf_flag", 32'(overflow), 1);
      check("lit_ovf_drop", 32'(drop_count), 2);
      check("lit_ovf_total", total_count, 13);
      for (int i = 1; i <= 8; i++) begin
         check("lit_ovf_drain", out_data, 32'(i));
         tick(0, 0, 1);
      end

      // full with simultaneous pop
      for (int i = 11; i <= 18; i++) tick(1, i, 0);
      tick(1, 99, 1);
      check("lit_fullpop_level", 32'(level), 8);
      check("lit_fullpop_drop", 32'(drop_count), 2);
      for (int i = 12; i <= 18; i++) begin
         check("lit_fullpop_drain", out_data, 32'(i));
         tick(0, 0, 1);
      end
      check("lit_fullpop_last", out_data, 99);
      tick(0, 0, 1);

      // clear with coincident pulse
      tick(1, 5, 0); tick(1, 6, 0); tick(1, 8, 0);
      tick(1, 55, 0, 1);
      check("lit_clr_level", 32'(level), 0);
      check("lit_clr_valid", 32'(out_valid), 0);
      check("lit_clr_total", total_count, 0);
      check("lit_clr_drop", 32'(drop_count), 0);
      check("lit_clr_ovf", 32'(overflow), 0);
      tick(1, 7, 0);
      check("lit_clr_next", out_data, 7);
      tick(0, 0, 1);

      // mid-operation reset
      for (int i = 0; i < 5; i++) tick(1, -100 - i, 0);
      check("lit_rst_pre_level", 32'(level), 5);
      tick(0, 0, 1, 0, 1);
      check("lit_rst_level", 32'(level), 0);
      check("lit_rst_valid", 32'(out_valid), 0);
      check("lit_rst_total", total_count, 0);
      tick(1, -42, 0);
      check("lit_rst_next", out_data, -42);
      check("lit_rst_next_level", 32'(level), 1);
      tick(0, 0, 1);
      tick(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
